// File: rtl/rf_uart_rx.sv
// 8N1 UART receiver for the RF receive path: recovers bytes from the RX line,
// writes good bytes to the RX FIFO and counts framing errors and overflows.
module rf_uart_rx #(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   input  logic        i_fifo_full,
   output logic        fifo_wr_en,
   output logic [7:0]  fifo_wr_data,
   output logic        rx_busy,
   output logic [31:0] rx_err_state,
   output logic [3:0]  dbg_state_o
);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } state_t;

   localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

   state_t      state_q;
   logic        sync1_q;
   logic        rx_s_q;
   logic        rx_s_d_q;
   logic [15:0] baud_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shreg_q;
   logic [15:0] frm_err_cnt_q;
   logic [15:0] ovf_cnt_q;

   logic        fall_d;
   logic        half_done_d;
   logic        bit_done_d;

   assign fall_d      = rx_s_d_q & ~rx_s_q;
   assign half_done_d = (baud_cnt_q == HALF_M1);
   assign bit_done_d  = (baud_cnt_q == FULL_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= 1'b1;
         rx_s_q        <= 1'b1;
         rx_s_d_q      <= 1'b1;
         state_q       <= IDLE;
         baud_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         shreg_q       <= '0;
         frm_err_cnt_q <= '0;
         ovf_cnt_q     <= '0;
         fifo_wr_en    <= 1'b0;
         fifo_wr_data  <= '0;
      end else begin
         sync1_q    <= uart_rx;
         rx_s_q     <= sync1_q;
         rx_s_d_q   <= rx_s_q;
         fifo_wr_en <= 1'b0;
         case (state_q)
            IDLE: begin
               baud_cnt_q <= '0;
               bit_cnt_q  <= '0;
               // Only a high-to-low transition arms a frame; a stuck-low line never does.
               if (fall_d) state_q <= START;
            end
            START: begin
               if (half_done_d) begin
                  baud_cnt_q <= '0;
                  state_q    <= rx_s_q ? IDLE : DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            DATA: begin
               if (bit_done_d) begin
                  baud_cnt_q <= '0;
                  shreg_q    <= {rx_s_q, shreg_q[7:1]};
                  bit_cnt_q  <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= STOP;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            STOP: begin
               // Returning to IDLE at mid-stop-bit leaves half a bit to catch the next start edge.
               if (bit_done_d) begin
                  baud_cnt_q <= '0;
                  state_q    <= IDLE;
                  if (!rx_s_q) begin
                     frm_err_cnt_q <= frm_err_cnt_q + 16'd1;
                  end else if (i_fifo_full) begin
                     ovf_cnt_q <= ovf_cnt_q + 16'd1;
                  end else begin
                     fifo_wr_en   <= 1'b1;
                     fifo_wr_data <= shreg_q;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_busy      = (state_q != IDLE);
   assign rx_err_state = {ovf_cnt_q, frm_err_cnt_q};
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rf_uart_rx.sv
// Self-checking bench for rf_uart_rx: vector table, hand-written corner
// sequences and randomized frames scored against a frame-level model.
module tb_rf_uart_rx;

   localparam int BAUD = 16;
   localparam int HALF = BAUD / 2;
   // Drive-to-write latency: 2 sync cycles, edge detect, half bit, 9 bits, registered write.
   localparam int WR_LAT = 3 + HALF + 9 * BAUD;

   logic        clk;
   logic        rst_n;
   logic        uart_rx;
   logic        i_fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        rx_busy;
   logic [31:0] rx_err_state;
   logic [3:0]  dbg_state;

   rf_uart_rx #(.BAUD_DIV(BAUD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_rx      (uart_rx),
      .i_fifo_full  (i_fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .rx_busy      (rx_busy),
      .rx_err_state (rx_err_state),
      .dbg_state_o  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard
   logic [7:0]  exp_q[$];
   int          st_q[$];
   logic [15:0] exp_frm = 16'd0;
   logic [15:0] exp_ovf = 16'd0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          wr_cnt = 0;
   logic [7:0]  last_wr = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && fifo_wr_en) begin
         wr_cnt++;
         last_wr = fifo_wr_data;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got 0x%02h expected no write (cycle %0d)", fifo_wr_data, cyc);
         end else begin
            check("wr_data", {24'd0, fifo_wr_data}, {24'd0, exp_q.pop_front()});
            check("wr_latency", cyc - st_q.pop_front(), WR_LAT);
         end
      end
   end

   // driver tasks (always entered and left on a negedge)
   task automatic idle(input int n);
      uart_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic full);
      i_fifo_full = full;
      if (!stop) exp_frm = exp_frm + 16'd1;
      else if (full) exp_ovf = exp_ovf + 16'd1;
      else begin
         exp_q.push_back(d);
         st_q.push_back(cyc);
      end
      uart_rx = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         repeat (BAUD) @(negedge clk);
      end
      uart_rx = stop;
      repeat (BAUD) @(negedge clk);
   endtask

   task automatic settle_check(input string name);
      idle(2 * BAUD);
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_err_state"}, rx_err_state, {exp_ovf, exp_frm});
   endtask

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic        full;
      int          exp_wr;
      logic [15:0] exp_frm_inc;
      logic [15:0] exp_ovf_inc;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int          wr_before;
      logic [31:0] err_before;
      logic [7:0]  cks;
      bit          fell;

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 16'd0, 16'd0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 16'd1, 16'd0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 0, 16'd0, 16'd1};
      vecs[3] = '{8'h55, 1'b1, 1'b0, 1, 16'd0, 16'd0};
      vecs[4] = '{8'h00, 1'b1, 1'b0, 1, 16'd0, 16'd0};
      vecs[5] = '{8'h80, 1'b0, 1'b1, 0, 16'd1, 16'd0};
      vecs[6] = '{8'h7E, 1'b1, 1'b1, 0, 16'd0, 16'd1};

      rst_n       = 1'b0;
      uart_rx     = 1'b1;
      i_fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wr_en", {31'd0, fifo_wr_en}, 0);
      check("rst_wr_data", {24'd0, fifo_wr_data}, 0);
      check("rst_busy", {31'd0, rx_busy}, 0);
      check("rst_err_state", rx_err_state, 0);
      rst_n = 1'b1;
      idle(5);

      // vector table
      for (int v = 0; v < 7; v++) begin
         wr_before  = wr_cnt;
         err_before = rx_err_state;
         send_frame(vecs[v].data, vecs[v].stop, vecs[v].full);
         i_fifo_full = 1'b0;
         idle(BAUD);
         check($sformatf("vec%0d_writes", v), wr_cnt - wr_before, vecs[v].exp_wr);
         check($sformatf("vec%0d_err_state", v), rx_err_state,
               {err_before[31:16] + vecs[v].exp_ovf_inc, err_before[15:0] + vecs[v].exp_frm_inc});
      end
      settle_check("table");

      // packet: 12 payload bytes plus XOR checksum, back to back
      cks = 8'h00;
      wr_before = wr_cnt;
      for (int i = 1; i <= 12; i++) begin
         send_frame(8'(i), 1'b1, 1'b0);
         cks = cks ^ 8'(i);
      end
      send_frame(cks, 1'b1, 1'b0);
      settle_check("packet");
      check("packet_writes", wr_cnt - wr_before, 13);
      check("packet_last", {24'd0, last_wr}, {24'd0, cks});

      // glitch: short low pulse must abort quietly
      wr_before  = wr_cnt;
      err_before = rx_err_state;
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      check("glitch_busy_rise", {31'd0, rx_busy}, 1);
      uart_rx = 1'b1;
      fell = 1'b0;
      for (int i = 0; i < HALF + 3 && !fell; i++) begin
         @(negedge clk);
         if (!rx_busy) fell = 1'b1;
      end
      check("glitch_busy_fall", {31'd0, fell}, 1);
      idle(BAUD);
      check("glitch_writes", wr_cnt - wr_before, 0);
      check("glitch_err_state", rx_err_state, err_before);

      // framing error, then a line held low must not re-arm
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (12 * BAUD) @(negedge clk);
      check("held_low_busy", {31'd0, rx_busy}, 0);
      check("held_low_err_state", rx_err_state, {exp_ovf, exp_frm});
      settle_check("held_low");

      // reset during data bit 3 of 0x96
      uart_rx = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         uart_rx = ((8'h96 >> i) & 8'h01) != 8'h00;
         repeat (BAUD) @(negedge clk);
      end
      uart_rx = 1'b0;
      repeat (HALF) @(negedge clk);
      check("pre_rst_busy", {31'd0, rx_busy}, 1);
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      @(negedge clk);
      check("midrst_wr_en", {31'd0, fifo_wr_en}, 0);
      check("midrst_wr_data", {24'd0, fifo_wr_data}, 0);
      check("midrst_busy", {31'd0, rx_busy}, 0);
      check("midrst_err_state", rx_err_state, 0);
      exp_frm = 16'd0;
      exp_ovf = 16'd0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      idle(2 * BAUD);
      wr_before = wr_cnt;
      send_frame(8'h5A, 1'b1, 1'b0);
      settle_check("post_rst");
      check("post_rst_writes", wr_cnt - wr_before, 1);

      // randomized frames against the frame-level model
      for (int f = 0; f < 40; f++) begin
         logic [7:0] d;
         logic       stop;
         logic       full;
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         full = ($urandom_range(0, 3) == 0);
         send_frame(d, stop, full);
         if (stop) idle($urandom_range(0, 20));
         else      idle($urandom_range(2, 20));
      end
      i_fifo_full = 1'b0;
      settle_check("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
